// File: rtl/dmem2_dual_port_responder.sv
// Two-slot data-memory responder: zero-fills the array after reset, then serves
// one access per slot per edge with registered, write-first read data.
//
// state | meaning
// CLEAR | walking clr_ptr through the array writing zeros; ports ignored
// RUN   | array initialised, ready=1, both slots serviced every edge
module dmem2_dual_port_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              ready,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   new_a, new_b;
  logic [DATA_W-1:0]   q_a_d, q_b_d;
  logic                collision_d;
  logic                same_addr;
  logic                clr_last;

  assign same_addr = (address_a == address_b);
  assign clr_last  = (clr_ptr_q == {ADDR_W{1'b1}});

  // Program order: slot b is younger, so its write wins over slot a's.
  assign new_a = (wren_b && same_addr) ? data_b :
                 wren_a                ? data_a : mem[address_a];
  assign new_b = wren_b                ? data_b :
                 (wren_a && same_addr) ? data_a : mem[address_b];

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    q_a_d       = '0;
    q_b_d       = '0;
    collision_d = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_last) state_d = RUN;
      end
      RUN: begin
        q_a_d       = new_a;
        q_b_d       = new_b;
        collision_d = wren_a && wren_b && same_addr;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      q_a       <= q_a_d;
      q_b       <= q_b_d;
      collision <= collision_d;
    end
  end

  // While reset is low state_q is forced to CLEAR, so RUN writes cannot land;
  // the only write possible then is a harmless zero to mem[0].
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      if (wren_a) mem[address_a] <= new_a;
      if (wren_b) mem[address_b] <= new_b;
    end
  end

  assign ready = (state_q == RUN);

endmodule

// File: tb/tb_dmem2_dual_port_responder.sv
// Scoreboard bench for dmem2_dual_port_responder at ADDR_W=4: the driver queues
// the expected response of each edge, a monitor compares after the edge.
module tb_dmem2_dual_port_responder;

  logic        clock;
  logic        reset;
  logic [3:0]  address_a, address_b;
  logic [31:0] data_a, data_b;
  logic        wren_a, wren_b;
  logic [31:0] q_a, q_b;
  logic        ready, collision;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ca;
    logic [31:0] ea;
    logic        cb;
    logic [31:0] eb;
    logic        ecol;
    logic        erdy;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  dmem2_dual_port_responder #(.ADDR_W(4), .DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .ready     (ready),
    .collision (collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one edge's inputs at a negedge, queue what the next posedge must show.
  task automatic cyc(input logic wa, input logic [3:0] aa, input logic [31:0] da,
                     input logic wb, input logic [3:0] ab, input logic [31:0] db,
                     input logic ca, input logic [31:0] ea,
                     input logic cb, input logic [31:0] eb,
                     input logic ecol, input logic erdy, input string nm);
    exp_t e;
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb;
    e.ecol = ecol; e.erdy = erdy; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input logic erdy, input string nm);
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, erdy, nm);
  endtask

  always begin
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.ca) chk({e.nm, ".q_a"}, q_a, e.ea);
      if (e.cb) chk({e.nm, ".q_b"}, q_b, e.eb);
      chk({e.nm, ".collision"}, {31'h0, collision}, {31'h0, e.ecol});
      chk({e.nm, ".ready"}, {31'h0, ready}, {31'h0, e.erdy});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    wren_a = 1'b0; address_a = '0; data_a = '0;
    wren_b = 1'b0; address_b = '0; data_b = '0;
    repeat (3) @(negedge clock);
    chk("rst.ready", {31'h0, ready}, 32'h0);
    chk("rst.q_a", q_a, 32'h0);
    reset = 1'b1;

    // T1 + T5: clear sequence; a write attempt at clear edge 2 must be ignored
    for (int e = 1; e <= 16; e++) begin
      if (e == 2)
        cyc(1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'h0,
            1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, "clr_wr");
      else
        idle(e == 16, $sformatf("clr%0d", e));
    end

    for (int i = 0; i < 16; i++)
      cyc(1'b0, 4'(i), 32'h0, 1'b0, 4'(15 - i), 32'h0,
          1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, $sformatf("sweep%0d", i));

    // T2
    cyc(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,
        1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1, "wr5");
    cyc(1'b0, 4'd3, 32'h0, 1'b0, 4'd5, 32'h0,
        1'b1, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "rd5");

    // T3
    cyc(1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2,
        1'b1, 32'h2, 1'b1, 32'h2, 1'b1, 1'b1, "dbl7");
    cyc(1'b0, 4'd7, 32'h0, 1'b0, 4'd7, 32'h0,
        1'b1, 32'h2, 1'b1, 32'h2, 1'b0, 1'b1, "rd7");

    // Distinct-address double write: no collision
    cyc(1'b1, 4'd1, 32'h11, 1'b1, 4'd4, 32'h44,
        1'b1, 32'h11, 1'b1, 32'h44, 1'b0, 1'b1, "wr1_4");

    // T4
    cyc(1'b0, 4'd9, 32'h0, 1'b1, 4'd9, 32'h55,
        1'b1, 32'h55, 1'b1, 32'h55, 1'b0, 1'b1, "xwf_b");
    cyc(1'b1, 4'd9, 32'h66, 1'b0, 4'd9, 32'h0,
        1'b1, 32'h66, 1'b1, 32'h66, 1'b0, 1'b1, "xwf_a");
    cyc(1'b0, 4'd9, 32'h0, 1'b0, 4'd1, 32'h0,
        1'b1, 32'h66, 1'b1, 32'h11, 1'b0, 1'b1, "rd9_1");
    cyc(1'b0, 4'd4, 32'h0, 1'b0, 4'd5, 32'h0,
        1'b1, 32'h44, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "rd4_5");

    // T6a: reset after 10 clear edges, clear restarts from zero
    reset = 1'b0;
    #1;
    chk("rst_run.ready", {31'h0, ready}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 10; e++)
      cyc(1'b1, 4'(e), 32'hFFFF_0000 | 32'(e), 1'b1, 4'(e + 1), 32'h77,
          1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, $sformatf("clrA%0d", e));
    reset = 1'b0;
    #1;
    chk("rst_clr.ready", {31'h0, ready}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 16; e++)
      idle(e == 16, $sformatf("clrB%0d", e));

    // T6b: reset in RUN after writing addr 2
    cyc(1'b1, 4'd2, 32'hA5, 1'b0, 4'd2, 32'h0,
        1'b1, 32'hA5, 1'b1, 32'hA5, 1'b0, 1'b1, "wr2");
    reset = 1'b0;
    #1;
    chk("rst_q.q_a", q_a, 32'h0);
    chk("rst_q.q_b", q_b, 32'h0);
    chk("rst_q.ready", {31'h0, ready}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 16; e++)
      idle(e == 16, $sformatf("clrC%0d", e));
    cyc(1'b0, 4'd2, 32'h0, 1'b0, 4'd5, 32'h0,
        1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, "rd2_5");
    cyc(1'b0, 4'd7, 32'h0, 1'b0, 4'd9, 32'h0,
        1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, "rd7_9");

    repeat (2) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
